// File: rtl/uart_console_pkg.sv
// Shared encodings and ASCII helpers for the UART decimal-entry console.
package uart_console_pkg;

    typedef enum logic [2:0] {
        M_INIT, M_PROMPT, M_READ, M_ECHO,
        M_ERASE, M_CONV, M_DONE, M_REPLY
    } main_state_e;

    typedef enum logic [1:0] {
        T_IDLE, T_REQ, T_WAIT_HI, T_WAIT_LO
    } tx_state_e;

    localparam int IDX_W = 5;
    localparam int CNT_W = 4;
    localparam int K_W   = 4;

    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_LF  = 8'h0A;
    localparam logic [7:0] ASC_BS  = 8'h08;
    localparam logic [7:0] ASC_DEL = 8'h7F;
    localparam logic [7:0] ASC_SP  = 8'h20;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// Byte sequencer: walks a message of len bytes through the uart
// transmitter handshake, fetching each byte via idx_nxt/ch.
module uart_tx_seq
    import uart_console_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [IDX_W-1:0] len,
    input  logic [7:0]       ch,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_byte,
    output logic [IDX_W-1:0] idx_nxt,
    output logic             idle,
    output logic             done
);

    tx_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= T_IDLE;
            idx_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
        end
    end

    assign idx_nxt = (state_q == T_IDLE) ? '0 : idx_q + 1'b1;
    assign idle    = (state_q == T_IDLE);
    assign tx_byte = byte_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        tx_start = 1'b0;
        done     = 1'b0;
        case (state_q)
            T_IDLE: if (start) begin
                state_d = T_REQ;
                idx_d   = '0;
                byte_d  = ch;
            end
            // hold the request off while a previous byte still drains
            T_REQ: if (!tx_busy) begin
                tx_start = 1'b1;
                state_d  = T_WAIT_HI;
            end
            T_WAIT_HI: if (tx_busy) state_d = T_WAIT_LO;
            T_WAIT_LO: if (!tx_busy) begin
                if (idx_nxt == len) begin
                    done    = 1'b1;
                    state_d = T_IDLE;
                end else begin
                    idx_d   = idx_nxt;
                    byte_d  = ch;
                    state_d = T_REQ;
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_num_console.sv
// UART decimal-entry console: prompts, echoes and edits operands,
// converts them with saturation and prints them back in hex.
module uart_num_console
    import uart_console_pkg::*;
#(
    parameter int NUM_W        = 16,
    parameter int MAX_DIGITS   = 5,
    parameter int NUM_OPERANDS = 2,
    parameter int INIT_DELAY   = 100_000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_byte,
    input  logic                          tx_busy,
    output logic                          tx_start,
    output logic [7:0]                    tx_byte,
    output logic                          nums_valid,
    output logic [NUM_W*NUM_OPERANDS-1:0] nums,
    output logic [NUM_OPERANDS-1:0]       ovf,
    output logic                          busy
);

    localparam int H  = NUM_W / 4;
    localparam int EW = NUM_W + 4;
    localparam logic [EW-1:0] SAT = {4'h0, {NUM_W{1'b1}}};

    main_state_e       state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cj_q, cj_d;
    logic [31:0]       dly_q, dly_d;
    logic [NUM_W-1:0]  acc_q, acc_d;
    logic              cov_q, cov_d;
    logic [7:0]        echo_q, echo_d;
    logic [3:0]        dig_q [MAX_DIGITS];
    logic [3:0]        dig_d [MAX_DIGITS];
    logic [NUM_W-1:0]  val_q [NUM_OPERANDS];
    logic [NUM_W-1:0]  val_d [NUM_OPERANDS];
    logic [NUM_OPERANDS-1:0] ovf_q, ovf_d;

    logic             tx_go, tx_idle, tx_done;
    logic [IDX_W-1:0] tx_len, tx_idx;
    logic [7:0]       tx_ch;

    logic [3:0]       cur_dig;
    logic [EW-1:0]    prod;
    logic             sat;
    logic [NUM_W-1:0] acc_nxt;
    logic             cov_nxt;
    logic [NUM_W-1:0] rv;
    logic             rv_ovf;
    logic             is_dig;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= M_INIT;
            k_q     <= '0;
            cnt_q   <= '0;
            cj_q    <= '0;
            dly_q   <= '0;
            acc_q   <= '0;
            cov_q   <= 1'b0;
            echo_q  <= '0;
            dig_q   <= '{default: '0};
            val_q   <= '{default: '0};
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            cj_q    <= cj_d;
            dly_q   <= dly_d;
            acc_q   <= acc_d;
            cov_q   <= cov_d;
            echo_q  <= echo_d;
            dig_q   <= dig_d;
            val_q   <= val_d;
            ovf_q   <= ovf_d;
        end
    end

    // conversion step and reply operand selection
    always_comb begin
        cur_dig = '0;
        rv      = '0;
        rv_ovf  = 1'b0;
        for (int j = 0; j < MAX_DIGITS; j++)
            if (cj_q == CNT_W'(j)) cur_dig = dig_q[j];
        for (int j = 0; j < NUM_OPERANDS; j++)
            if (k_q == K_W'(j)) begin
                rv     = val_q[j];
                rv_ovf = ovf_q[j];
            end
        prod    = EW'(acc_q) * EW'(10) + EW'(cur_dig);
        sat     = prod > SAT;
        acc_nxt = sat ? '1 : prod[NUM_W-1:0];
        cov_nxt = cov_q | sat;
    end

    assign is_dig = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        cj_d       = cj_q;
        dly_d      = dly_q;
        acc_d      = acc_q;
        cov_d      = cov_q;
        echo_d     = echo_q;
        dig_d      = dig_q;
        val_d      = val_q;
        ovf_d      = ovf_q;
        nums_valid = 1'b0;
        case (state_q)
            M_INIT: begin
                if (dly_q == 32'(INIT_DELAY - 1)) begin
                    state_d = M_PROMPT;
                    dly_d   = '0;
                    ovf_d   = '0;
                    cnt_d   = '0;
                    dig_d   = '{default: '0};
                end else begin
                    dly_d = dly_q + 32'd1;
                end
            end
            M_PROMPT, M_ECHO, M_ERASE:
                if (tx_done) state_d = M_READ;
            M_READ: if (rx_valid) begin
                unique case (1'b1)
                    is_dig && (cnt_q < CNT_W'(MAX_DIGITS)): begin
                        for (int j = 0; j < MAX_DIGITS; j++)
                            if (cnt_q == CNT_W'(j)) dig_d[j] = rx_byte[3:0];
                        cnt_d   = cnt_q + 1'b1;
                        echo_d  = rx_byte;
                        state_d = M_ECHO;
                    end
                    (rx_byte == ASC_BS || rx_byte == ASC_DEL)
                        && (cnt_q != '0): begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = M_ERASE;
                    end
                    (rx_byte == ASC_CR) && (cnt_q != '0): begin
                        cj_d    = '0;
                        acc_d   = '0;
                        cov_d   = 1'b0;
                        state_d = M_CONV;
                    end
                    default: ;
                endcase
            end
            M_CONV: begin
                if (cj_q == cnt_q - 1'b1) begin
                    for (int j = 0; j < NUM_OPERANDS; j++)
                        if (k_q == K_W'(j)) begin
                            val_d[j] = acc_nxt;
                            ovf_d[j] = cov_nxt;
                        end
                    if (k_q == K_W'(NUM_OPERANDS - 1)) begin
                        state_d = M_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        cnt_d   = '0;
                        dig_d   = '{default: '0};
                        state_d = M_PROMPT;
                    end
                end else begin
                    cj_d  = cj_q + 1'b1;
                    acc_d = acc_nxt;
                    cov_d = cov_nxt;
                end
            end
            M_DONE: begin
                nums_valid = 1'b1;
                k_d        = '0;
                state_d    = M_REPLY;
            end
            // k == NUM_OPERANDS selects the closing CR/LF
            M_REPLY: if (tx_done) begin
                if (k_q == K_W'(NUM_OPERANDS)) begin
                    k_d     = '0;
                    dly_d   = '0;
                    state_d = M_INIT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = M_INIT;
        endcase
    end

    always_comb begin
        tx_ch  = 8'h00;
        tx_len = '0;
        tx_go  = tx_idle && (state_q == M_PROMPT || state_q == M_ECHO
                 || state_q == M_ERASE || state_q == M_REPLY);
        case (state_q)
            M_PROMPT: begin
                tx_len = IDX_W'(18);
                case (tx_idx)
                    5'd0:  tx_ch = ASC_CR;
                    5'd1:  tx_ch = ASC_LF;
                    5'd2:  tx_ch = "E";
                    5'd3:  tx_ch = "n";
                    5'd4:  tx_ch = "t";
                    5'd5:  tx_ch = "e";
                    5'd6:  tx_ch = "r";
                    5'd7:  tx_ch = ASC_SP;
                    5'd8:  tx_ch = "n";
                    5'd9:  tx_ch = "u";
                    5'd10: tx_ch = "m";
                    5'd11: tx_ch = "b";
                    5'd12: tx_ch = "e";
                    5'd13: tx_ch = "r";
                    5'd14: tx_ch = ASC_SP;
                    5'd15: tx_ch = 8'h31 + 8'(k_q);
                    5'd16: tx_ch = ":";
                    5'd17: tx_ch = ASC_SP;
                    default: tx_ch = 8'h00;
                endcase
            end
            M_ECHO: begin
                tx_len = IDX_W'(1);
                tx_ch  = echo_q;
            end
            M_ERASE: begin
                tx_len = IDX_W'(3);
                tx_ch  = (tx_idx == 5'd1) ? ASC_SP : ASC_BS;
            end
            M_REPLY: begin
                if (k_q == K_W'(NUM_OPERANDS)) begin
                    tx_len = IDX_W'(2);
                    tx_ch  = (tx_idx == 5'd0) ? ASC_CR : ASC_LF;
                end else begin
                    tx_len = IDX_W'(13 + H) + IDX_W'(rv_ovf);
                    case (tx_idx)
                        5'd0:  tx_ch = ASC_CR;
                        5'd1:  tx_ch = ASC_LF;
                        5'd2:  tx_ch = "V";
                        5'd3:  tx_ch = "a";
                        5'd4:  tx_ch = "l";
                        5'd5:  tx_ch = "u";
                        5'd6:  tx_ch = "e";
                        5'd7:  tx_ch = ASC_SP;
                        5'd8:  tx_ch = 8'h31 + 8'(k_q);
                        5'd9:  tx_ch = ":";
                        5'd10: tx_ch = ASC_SP;
                        5'd11: tx_ch = "0";
                        5'd12: tx_ch = "x";
                        default: tx_ch = "!";
                    endcase
                    for (int n = 0; n < H; n++)
                        if (tx_idx == IDX_W'(12 + H - n))
                            tx_ch = hex_ascii(rv[4*n +: 4]);
                end
            end
            default: ;
        endcase
    end

    uart_tx_seq u_tx_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (tx_go),
        .len      (tx_len),
        .ch       (tx_ch),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .idx_nxt  (tx_idx),
        .idle     (tx_idle),
        .done     (tx_done)
    );

    for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_nums
        assign nums[g*NUM_W +: NUM_W] = val_q[g];
    end

    assign ovf  = ovf_q;
    assign busy = (state_q != M_READ);

endmodule

// File: tb/tb_uart_num_console.sv
// Scoreboard bench for uart_num_console: expected tx bytes and operand
// sets are queued by the stimulus and checked by a negedge monitor.
module tb_uart_num_console;

    localparam int NW  = 16;
    localparam int ND  = 5;
    localparam int NO  = 2;
    localparam int DLY = 40;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          nums_valid;
    logic [NW*NO-1:0] nums;
    logic [NO-1:0] ovf;
    logic          busy;

    logic [7:0]    exp_q [$];
    logic [31:0]   expn_q [$];
    logic [1:0]    expo_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_tx    = 0;
    int n_nv    = 0;
    int bcnt    = 0;

    always #5 clk = ~clk;

    uart_num_console #(
        .NUM_W        (NW),
        .MAX_DIGITS   (ND),
        .NUM_OPERANDS (NO),
        .INIT_DELAY   (DLY)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .nums_valid (nums_valid),
        .nums       (nums),
        .ovf        (ovf),
        .busy       (busy)
    );

    // uart transmitter stand-in: busy for 4 cycles after each request
    always @(posedge clk) begin
        if (tx_start && !tx_busy) begin
            tx_busy <= 1'b1;
            bcnt    <= 4;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) tx_busy <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_start) begin
                n_tx++;
                check("tx_start_while_busy", 64'(tx_busy), 64'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got %0h expected none",
                             tx_byte);
                end else begin
                    check("tx_byte", 64'(tx_byte), 64'(exp_q.pop_front()));
                end
            end
            if (nums_valid) begin
                n_nv++;
                if (expn_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL nums_unexpected: got %0h expected none",
                             nums);
                end else begin
                    check("nums", 64'(nums), 64'(expn_q.pop_front()));
                    check("ovf", 64'(ovf), 64'(expo_q.pop_front()));
                end
            end
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    endtask

    task automatic push_crlf();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_prompt(input int k);
        push_crlf();
        push_str("Enter number ");
        exp_q.push_back(8'h31 + 8'(k));
        push_str(": ");
    endtask

    task automatic push_reply(input int k, input string hex, input bit o);
        push_crlf();
        push_str("Value ");
        exp_q.push_back(8'h31 + 8'(k));
        push_str(": 0x");
        push_str(hex);
        if (o) push_str("!");
    endtask

    task automatic pulse(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_ready(input string what);
        int t = 0;
        while (busy && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check({"ready_", what}, 64'(busy), 64'd0);
    endtask

    task automatic key(input logic [7:0] b, input bit echo);
        if (echo) exp_q.push_back(b);
        pulse(b);
        wait_ready("key");
    endtask

    task automatic quiet_window(input string what);
        int early = 0;
        repeat (DLY) begin
            @(negedge clk);
            if (tx_start) early++;
        end
        check({"quiet_", what}, 64'(early), 64'd0);
    endtask

    initial begin
        int t;
        int base;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_tx_byte", 64'(tx_byte), 64'd0);
        check("rst_nums_valid", 64'(nums_valid), 64'd0);
        check("rst_nums", 64'(nums), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);

        push_prompt(0);
        reset_n = 1'b1;
        quiet_window("init");
        t = 0;
        while (!tx_start && t < 5) begin
            @(negedge clk);
            t++;
        end
        check("prompt_latency", 64'(tx_start), 64'd1);
        wait_ready("prompt1");

        // round 1: plain entry, junk byte, drops during PROMPT/REPLY
        key("1", 1);
        key("a", 0);
        key("2", 1);
        key("3", 1);
        key("4", 1);
        push_prompt(1);
        pulse(8'h0D);
        repeat (20) @(negedge clk);
        pulse("7");
        wait_ready("op2");
        key("6", 1);
        key("5", 1);
        key("5", 1);
        key("3", 1);
        key("5", 1);
        expn_q.push_back({16'hFFFF, 16'h04D2});
        expo_q.push_back(2'b00);
        push_reply(0, "04D2", 0);
        push_reply(1, "FFFF", 0);
        push_crlf();
        push_prompt(0);
        pulse(8'h0D);
        repeat (30) @(negedge clk);
        pulse("3");
        wait_ready("round2");

        // round 2: empty BS/CR, saturation, sixth digit, edit
        key(8'h08, 0);
        key(8'h0D, 0);
        repeat (5) key("9", 1);
        key("9", 0);
        push_prompt(1);
        pulse(8'h0D);
        wait_ready("r2op2");
        key("1", 1);
        key("2", 1);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h08);
        pulse(8'h08);
        wait_ready("erase");
        key("5", 1);
        expn_q.push_back({16'h000F, 16'hFFFF});
        expo_q.push_back(2'b01);
        push_reply(0, "FFFF", 1);
        push_reply(1, "000F", 0);
        push_crlf();
        push_prompt(0);
        pulse(8'h0D);
        wait_ready("round3");
        check("nums_hold", 64'(nums), 64'h000F_FFFF);
        check("ovf_cleared", 64'(ovf), 64'd0);

        // round 3: reset while the reply is in flight
        key("1", 1);
        push_prompt(1);
        pulse(8'h0D);
        wait_ready("r3op2");
        key("2", 1);
        expn_q.push_back({16'h0002, 16'h0001});
        expo_q.push_back(2'b00);
        push_reply(0, "0001", 0);
        push_reply(1, "0002", 0);
        push_crlf();
        pulse(8'h0D);
        t = 0;
        while (n_nv < 3 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("nums_valid_count", 64'(n_nv), 64'd3);
        base = n_tx;
        t = 0;
        while (n_tx < base + 5 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("reply_progress", 64'(n_tx - base), 64'd5);
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_tx_start", 64'(tx_start), 64'd0);
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_nums", 64'(nums), 64'd0);
        push_prompt(0);
        reset_n = 1'b1;
        quiet_window("restart");
        wait_ready("restart");
        check("tx_queue_drained", 64'(exp_q.size()), 64'd0);
        check("nums_valid_total", 64'(n_nv), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
